// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: MEM stage of a 5-stage MIPS pipeline.
//   Holds the EX/MEM pipeline register, resolves branches/jumps, masters the
//   data-memory bus for lw/sw (valid/ready request, valid-only response) and
//   stalls upstream stages while an access is outstanding.
// Ports:
//   CLK, RSTn                 clock (rising edge), async active-low reset
//   *E, *_in                  EX-stage outputs captured when stallM = 0
//   mem_req_*                 bus request (valid/ready handshake, we, addr, wdata)
//   mem_rsp_valid/rdata       load response (valid only)
//   RegWriteM .. wb_addr_M    results presented to WB
//   PCSrcM, PCTargetM         redirect to IF
//   stallM                    hold IF/ID/EX and this register
//   mem_timeout               one-cycle pulse when a load is force-completed
// Build option:
//   MEM_ALIGN_CHECK_EN        adds mem_misalign; misaligned lw/sw skip the bus
module mem_stage_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter bit          WORD_ADDR      = 1'b1
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        RegWriteE,
    input  logic        MemtoRegE,
    input  logic        MemWriteE,
    input  logic        BranchE,
    input  logic        JumpE,
    input  logic [5:0]  ALUopE,
    input  logic [31:0] ALUOut_in,
    input  logic [31:0] WriteData_in,
    input  logic [31:0] PCPlus4_in,
    input  logic [31:0] PCBranch_in,
    input  logic [4:0]  wb_addr_in,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_req_we,
    output logic [31:0] mem_req_addr,
    output logic [31:0] mem_req_wdata,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_rdata,
    output logic        RegWriteM,
    output logic        MemtoRegM,
    output logic [5:0]  ALUopM,
    output logic [31:0] ALUOutM,
    output logic [31:0] ReadDataM,
    output logic [31:0] PCPlus4M,
    output logic [4:0]  wb_addr_M,
    output logic        PCSrcM,
    output logic [31:0] PCTargetM,
    output logic        stallM,
    output logic        mem_timeout
`ifdef MEM_ALIGN_CHECK_EN
    ,
    output logic        mem_misalign
`endif
);

    typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;

    state_t      state_q, state_d;
    logic        reg_write_q;
    logic        mem_write_q;
    logic        branch_q;
    logic        jump_q;
    logic [31:0] wdata_q;
    logic [31:0] pc_branch_q;
    logic [15:0] wait_cnt;
    logic        timeout_hit;
    logic        misalign_in;
    logic        mem_op_in;
    logic [31:0] addr_aligned;

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign_in  = (ALUOut_in[1:0] != 2'b00);
    // misaligned accesses never reach the bus, so the address is used as-is
    assign addr_aligned = ALUOutM;
`else
    assign misalign_in  = 1'b0;
    assign addr_aligned = {ALUOutM[31:2], 2'b00};
`endif

    assign mem_op_in   = (MemtoRegE | MemWriteE) & ~misalign_in;
    assign timeout_hit = (state_q == RSP) && !mem_rsp_valid &&
                         (wait_cnt == 16'(TIMEOUT_CYCLES - 1));

    assign stallM        = (state_q != IDLE);
    assign mem_req_valid = (state_q == REQ);
    assign mem_req_we    = mem_write_q;
    assign mem_req_wdata = wdata_q;
    assign mem_req_addr  = WORD_ADDR ? {2'b00, addr_aligned[31:2]} : addr_aligned;

    assign RegWriteM = reg_write_q & ~stallM;
    assign PCSrcM    = jump_q | (branch_q & (ALUOutM == 32'd1));
    assign PCTargetM = jump_q ? ALUOutM : pc_branch_q;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (mem_op_in) state_d = REQ;
            REQ:  if (mem_req_ready) state_d = mem_write_q ? IDLE : RSP;
            RSP:  if (mem_rsp_valid || timeout_hit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            reg_write_q <= 1'b0;
            MemtoRegM   <= 1'b0;
            mem_write_q <= 1'b0;
            branch_q    <= 1'b0;
            jump_q      <= 1'b0;
            ALUopM      <= '0;
            ALUOutM     <= '0;
            wdata_q     <= '0;
            PCPlus4M    <= '0;
            pc_branch_q <= '0;
            wb_addr_M   <= '0;
            ReadDataM   <= '0;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
            mem_misalign <= 1'b0;
`endif
        end else begin
            mem_timeout <= timeout_hit;
            // counter is zero on every RSP entry because REQ keeps it cleared
            wait_cnt    <= (state_q == RSP) ? wait_cnt + 16'd1 : '0;
`ifdef MEM_ALIGN_CHECK_EN
            mem_misalign <= 1'b0;
`endif
            if (!stallM) begin
                reg_write_q <= RegWriteE;
                MemtoRegM   <= MemtoRegE;
                mem_write_q <= MemWriteE;
                branch_q    <= BranchE;
                jump_q      <= JumpE;
                ALUopM      <= ALUopE;
                ALUOutM     <= ALUOut_in;
                wdata_q     <= WriteData_in;
                PCPlus4M    <= PCPlus4_in;
                pc_branch_q <= PCBranch_in;
                wb_addr_M   <= wb_addr_in;
`ifdef MEM_ALIGN_CHECK_EN
                if ((MemtoRegE | MemWriteE) && misalign_in) begin
                    mem_misalign <= 1'b1;
                    if (MemtoRegE) ReadDataM <= '0;
                end
`endif
            end
            if (state_q == RSP && mem_rsp_valid) begin
                ReadDataM <= mem_rsp_rdata;
            end else if (timeout_hit) begin
                ReadDataM <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl (default build, TIMEOUT_CYCLES=4,
// WORD_ADDR=1). A transaction-level model tracks the captured instruction and
// whether its memory access is still open; a compare process checks every
// output each cycle, and directed sequences pin key values with literals.
module tb_mem_stage_ctrl;

    localparam int unsigned TMO = 4;

    logic        CLK = 1'b0;
    logic        RSTn;
    logic        RegWriteE, MemtoRegE, MemWriteE, BranchE, JumpE;
    logic [5:0]  ALUopE;
    logic [31:0] ALUOut_in, WriteData_in, PCPlus4_in, PCBranch_in;
    logic [4:0]  wb_addr_in;
    logic        mem_req_valid, mem_req_ready, mem_req_we;
    logic [31:0] mem_req_addr, mem_req_wdata;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_rdata;
    logic        RegWriteM, MemtoRegM;
    logic [5:0]  ALUopM;
    logic [31:0] ALUOutM, ReadDataM, PCPlus4M;
    logic [4:0]  wb_addr_M;
    logic        PCSrcM;
    logic [31:0] PCTargetM;
    logic        stallM, mem_timeout;

    int errors = 0;
    int checks = 0;

    mem_stage_ctrl #(.TIMEOUT_CYCLES(TMO), .WORD_ADDR(1'b1)) dut (
        .CLK(CLK), .RSTn(RSTn),
        .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
        .BranchE(BranchE), .JumpE(JumpE), .ALUopE(ALUopE),
        .ALUOut_in(ALUOut_in), .WriteData_in(WriteData_in),
        .PCPlus4_in(PCPlus4_in), .PCBranch_in(PCBranch_in), .wb_addr_in(wb_addr_in),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
        .mem_req_wdata(mem_req_wdata),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
        .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .ALUopM(ALUopM),
        .ALUOutM(ALUOutM), .ReadDataM(ReadDataM), .PCPlus4M(PCPlus4M),
        .wb_addr_M(wb_addr_M), .PCSrcM(PCSrcM), .PCTargetM(PCTargetM),
        .stallM(stallM), .mem_timeout(mem_timeout)
    );

    always #5 CLK = ~CLK;

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic        rw, m2r, mw, br, jp;
        logic [5:0]  op;
        logic [31:0] alu, wd, pc4, pcb;
        logic [4:0]  wa;
    } inst_t;

    inst_t       m_inst;
    logic        m_busy;    // captured instruction still has an open access
    logic        m_acked;   // its request has been accepted (load awaiting data)
    logic [31:0] m_rdata;
    logic        m_tmo;
    int unsigned cyc, hs_cyc;

    always @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            m_inst  <= '0;
            m_busy  <= 1'b0;
            m_acked <= 1'b0;
            m_rdata <= '0;
            m_tmo   <= 1'b0;
            cyc     <= 0;
            hs_cyc  <= 0;
        end else begin
            cyc   <= cyc + 1;
            m_tmo <= 1'b0;
            if (!m_busy) begin
                m_inst <= '{RegWriteE, MemtoRegE, MemWriteE, BranchE, JumpE, ALUopE,
                            ALUOut_in, WriteData_in, PCPlus4_in, PCBranch_in, wb_addr_in};
                m_acked <= 1'b0;
                if (MemtoRegE || MemWriteE) m_busy <= 1'b1;
            end else if (!m_acked) begin
                if (mem_req_ready) begin
                    if (m_inst.mw) m_busy <= 1'b0;
                    else begin
                        m_acked <= 1'b1;
                        hs_cyc  <= cyc;
                    end
                end
            end else if (mem_rsp_valid) begin
                m_rdata <= mem_rsp_rdata;
                m_busy  <= 1'b0;
            end else if (cyc - hs_cyc == TMO) begin
                m_rdata <= '0;
                m_tmo   <= 1'b1;
                m_busy  <= 1'b0;
            end
        end
    end

    always @(negedge CLK) begin
        chk1("stallM", stallM, m_busy);
        chk1("mem_req_valid", mem_req_valid, m_busy & ~m_acked);
        if (m_busy & ~m_acked) begin
            chk32("mem_req_addr", mem_req_addr, {2'b00, m_inst.alu[31:2]});
            chk1("mem_req_we", mem_req_we, m_inst.mw);
            if (m_inst.mw) chk32("mem_req_wdata", mem_req_wdata, m_inst.wd);
        end
        chk1("RegWriteM", RegWriteM, m_inst.rw & ~m_busy);
        chk1("MemtoRegM", MemtoRegM, m_inst.m2r);
        chk32("ALUopM", {26'd0, ALUopM}, {26'd0, m_inst.op});
        chk32("ALUOutM", ALUOutM, m_inst.alu);
        chk32("PCPlus4M", PCPlus4M, m_inst.pc4);
        chk32("wb_addr_M", {27'd0, wb_addr_M}, {27'd0, m_inst.wa});
        chk32("ReadDataM", ReadDataM, m_rdata);
        chk1("mem_timeout", mem_timeout, m_tmo);
        chk1("PCSrcM", PCSrcM, m_inst.jp | (m_inst.br & (m_inst.alu == 32'd1)));
        chk32("PCTargetM", PCTargetM, m_inst.jp ? m_inst.alu : m_inst.pcb);
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge CLK);
        #2;
    endtask

    task automatic drive(input logic rw, m2r, mw, br, jp,
                         input logic [31:0] alu, wd, pcb, input logic [4:0] wa);
        RegWriteE    = rw;
        MemtoRegE    = m2r;
        MemWriteE    = mw;
        BranchE      = br;
        JumpE        = jp;
        ALUopE       = 6'($urandom);
        ALUOut_in    = alu;
        WriteData_in = wd;
        PCPlus4_in   = $urandom;
        PCBranch_in  = pcb;
        wb_addr_in   = wa;
    endtask

    task automatic nop();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0);
    endtask

    initial begin
        RSTn = 1'b0;
        mem_req_ready = 1'b1;
        mem_rsp_valid = 1'b0;
        mem_rsp_rdata = '0;
        nop();
        step();
        step();
        chk1("rst_stallM", stallM, 1'b0);
        chk1("rst_req_valid", mem_req_valid, 1'b0);
        chk32("rst_ALUOutM", ALUOutM, 32'd0);
        chk32("rst_ReadDataM", ReadDataM, 32'd0);
        chk1("rst_RegWriteM", RegWriteM, 1'b0);
        chk1("rst_PCSrcM", PCSrcM, 1'b0);
        RSTn = 1'b1;

        // add
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h10, 32'd0, 32'd0, 5'd8);
        step();
        nop();
        #2;
        chk1("add_RegWriteM", RegWriteM, 1'b1);
        chk32("add_ALUOutM", ALUOutM, 32'h10);
        chk32("add_wb_addr", {27'd0, wb_addr_M}, 32'd8);
        chk1("add_stallM", stallM, 1'b0);
        step();

        // sw with ready held off for 3 cycles
        mem_req_ready = 1'b0;
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h100, 32'hCAFE_F00D, 32'd0, 5'd0);
        step();
        nop();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) mem_req_ready = 1'b1;
            #2;
            chk1("sw_valid", mem_req_valid, 1'b1);
            chk32("sw_addr", mem_req_addr, 32'h40);
            chk1("sw_we", mem_req_we, 1'b1);
            chk32("sw_wdata", mem_req_wdata, 32'hCAFE_F00D);
            chk1("sw_stall", stallM, 1'b1);
            step();
        end
        #2;
        chk1("sw_done_stall", stallM, 1'b0);
        chk1("sw_done_valid", mem_req_valid, 1'b0);
        step();

        // lw, response two cycles after handshake
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h20, 32'd0, 32'd0, 5'd9);
        step();
        nop();
        #2;
        chk1("lw_valid", mem_req_valid, 1'b1);
        chk32("lw_addr", mem_req_addr, 32'h8);
        chk1("lw_we", mem_req_we, 1'b0);
        step();
        #2;
        chk1("lw_rsp_stall", stallM, 1'b1);
        chk1("lw_rsp_regwrite", RegWriteM, 1'b0);
        step();
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 32'h1234_5678;
        step();
        mem_rsp_valid = 1'b0;
        #2;
        chk32("lw_rdata", ReadDataM, 32'h1234_5678);
        chk1("lw_memtoreg", MemtoRegM, 1'b1);
        chk1("lw_regwrite", RegWriteM, 1'b1);
        chk1("lw_stall_drop", stallM, 1'b0);
        step();
        #2;
        chk1("lw_regwrite_once", RegWriteM, 1'b0);
        step();

        // lw that times out
        mem_req_ready = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h44, 32'd0, 32'd0, 5'd3);
        step();
        nop();
        step();
        step();
        step();
        step();
        #2;
        chk1("tmo_last_stall", stallM, 1'b1);
        chk1("tmo_not_yet", mem_timeout, 1'b0);
        step();
        #2;
        chk1("tmo_pulse", mem_timeout, 1'b1);
        chk32("tmo_rdata", ReadDataM, 32'd0);
        chk1("tmo_stall_drop", stallM, 1'b0);
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 32'hDEAD_BEEF;
        step();
        mem_rsp_valid = 1'b0;
        #2;
        chk32("late_rsp_ignored", ReadDataM, 32'd0);
        chk1("tmo_pulse_end", mem_timeout, 1'b0);
        step();

        // beq taken, beq not taken, j
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd1, 32'd0, 32'h48, 5'd0);
        step();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 32'h80, 5'd0);
        #2;
        chk1("beq_pcsrc", PCSrcM, 1'b1);
        chk32("beq_target", PCTargetM, 32'h48);
        step();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0040_0000, 32'd0, 32'h99, 5'd0);
        #2;
        chk1("beq_nt_pcsrc", PCSrcM, 1'b0);
        step();
        nop();
        #2;
        chk1("j_pcsrc", PCSrcM, 1'b1);
        chk32("j_target", PCTargetM, 32'h0040_0000);
        step();

        // reset asserted while a request is pending
        mem_req_ready = 1'b0;
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h200, 32'h5555_AAAA, 32'd0, 5'd0);
        step();
        nop();
        #2;
        chk1("midreq_valid", mem_req_valid, 1'b1);
        RSTn = 1'b0;
        #1;
        chk1("midreq_rst_valid", mem_req_valid, 1'b0);
        chk1("midreq_rst_stall", stallM, 1'b0);
        step();
        RSTn = 1'b1;

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            int unsigned sel;
            logic [31:0] a;
            sel = $urandom % 5;
            a = $urandom;
            case (sel)
                0: drive(1'($urandom), 1'b0, 1'b0, 1'b0, 1'b0, a, $urandom, $urandom, 5'($urandom));
                1: drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, a, $urandom, $urandom, 5'($urandom));
                2: drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, a, $urandom, $urandom, 5'($urandom));
                3: drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ($urandom % 2 == 0) ? 32'd1 : {31'd0, a[0]} + a[31:30],
                         $urandom, $urandom, 5'($urandom));
                default: drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, a, $urandom, $urandom, 5'($urandom));
            endcase
            mem_req_ready = 1'($urandom);
            mem_rsp_valid = ($urandom % 4 == 0);
            mem_rsp_rdata = $urandom;
            RSTn = ($urandom % 200 != 0);
            step();
        end
        RSTn = 1'b1;
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- MEM stage of the 5-stage MIPS pipeline; consumer end of the EX-stage output interface.
- Holds the EX/MEM pipeline register and resolves branches/jumps.
- Acts as data-memory bus master (valid/ready request, valid-only response) for lw/sw.
- Stalls upstream stages while a memory access is outstanding; presents results to WB.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles in RSP before a load is force-completed (1..65535).
- WORD_ADDR, 1: 1 = bus address is byte address >> 2; 0 = byte address as-is.

Ports:
- CLK in 1: clock, rising edge.
- RSTn in 1: asynchronous active-low reset.
- RegWriteE, MemtoRegE, MemWriteE, BranchE, JumpE in 1 each: control from EX.
- ALUopE in 6: opcode from EX.
- ALUOut_in in 32: ALU result: address, branch flag (1 = take), or jump target.
- WriteData_in in 32: store data.
- PCPlus4_in in 32 / PCBranch_in in 32: sequential PC / branch target.
- wb_addr_in in 5: destination register.
- mem_req_valid out 1; mem_req_ready in 1; mem_req_we out 1: bus request handshake and write enable.
- mem_req_addr out 32 / mem_req_wdata out 32: bus address and write data.
- mem_rsp_valid in 1 / mem_rsp_rdata in 32: load response.
- RegWriteM, MemtoRegM out 1; ALUopM out 6; ALUOutM, ReadDataM, PCPlus4M out 32; wb_addr_M out 5: to WB.
- PCSrcM out 1 / PCTargetM out 32: redirect to IF.
- stallM out 1: hold IF/ID/EX and this register.
- mem_timeout out 1: one-cycle pulse when a load times out.

Behaviour:
- Reset (async, RSTn=0): all registers and outputs 0, state IDLE, mem_req_valid 0 immediately. A reset mid-access abandons the access; a later response is ignored because state is IDLE.
- EX/MEM register loads all *_in/*E inputs on the posedge CLK where stallM=0; it holds while stallM=1.
- FSM states: IDLE, REQ, RSP.
- IDLE: on a capture with MemtoRegE=1 or MemWriteE=1, go to REQ on the same edge. Otherwise stay in IDLE.
- REQ: mem_req_valid=1. addr/we/wdata come from registered values and stay stable until the handshake (valid & ready).
  - On handshake: store (we=1) -> IDLE (posted write); load -> RSP.
- RSP: on mem_rsp_valid=1, latch rdata into ReadDataM and go to IDLE.
  - A wait counter starts at 0 on entry. If it reaches TIMEOUT_CYCLES without a response: ReadDataM=0, mem_timeout pulses for 1 cycle, go to IDLE.
- mem_rsp_valid is ignored in IDLE and REQ. The response must come at least 1 cycle after the handshake.
- stallM = (state != IDLE), combinational from state.
- RegWriteM = registered RegWrite & ~stallM. This gives exactly one write per instruction.
- Other WB outputs are registered values passed through.
- Load latency with ready=1 and response 1 cycle after handshake: 2 stall cycles. Store with ready=1: 1 stall cycle. Non-memory op: 0 stall cycles, result visible the cycle after capture.
- mem_req_addr = WORD_ADDR ? {2'b00, ALUOutM[31:2]} : ALUOutM.
- Branch/jump: PCSrcM = JumpM | (BranchM & (ALUOutM == 32'd1)); combinational, not gated by stallM.
  - PCTargetM = JumpM ? ALUOutM : PCBranchM.
- A branch/jump and a memory op are mutually exclusive per instruction. No priority logic is needed beyond the formulas above.

Optional Feature:
- MEM_ALIGN_CHECK_EN defined:
  - Adds output mem_misalign (1 bit).
  - A lw/sw with ALUOut_in[1:0] != 0 issues no bus request and stays in IDLE (no stall).
  - mem_misalign pulses 1 cycle; the load returns ReadDataM=0; the store is dropped.
- Not defined:
  - No port.
  - Address bits [1:0] are forced to 00 before address formatting.

Test Plan:
- Reset: hold RSTn=0 with mem_req_ready=1 -> all outputs 0, stallM=0. Assert RSTn=0 mid-REQ -> mem_req_valid drops in the same cycle without waiting for a clock.
- add result 0x0000_0010, wb_addr 5'd8, RegWrite=1 -> next cycle RegWriteM=1, ALUOutM=0x10, wb_addr_M=8, stallM=0.
- sw addr 0x0000_0100, data 0xCAFE_F00D, ready delayed 3 cycles, WORD_ADDR=1 -> mem_req_addr=0x40 and we=1 held stable 4 cycles. stallM=1 for 4 cycles, then IDLE.
- lw addr 0x0000_0020, ready=1, rsp 2 cycles after handshake with 0x1234_5678 -> ReadDataM=0x1234_5678, MemtoRegM=1, RegWriteM pulses once after stall drops.
- lw with no response, TIMEOUT_CYCLES=4 -> mem_timeout pulses after 4 RSP cycles, ReadDataM=0, stallM drops. A late rsp_valid is ignored.
- beq with ALUOut=1, PCBranch=0x0000_0048 -> PCSrcM=1, PCTargetM=0x48. j with ALUOut=0x0040_0000 -> PCSrcM=1, PCTargetM=0x0040_0000.
